// File: rtl/fetch_prefetch_q.sv
// fetch_prefetch_q
//   Y-86 fetch stage built around a byte-wide prefetch queue. Instruction
//   memory is read FETCH_BYTES at a time. The raw bytes, each with its own
//   fault flag, are pushed into a circular queue. The instruction at the
//   queue head is decoded combinationally and offered to decode through a
//   valid/ready handshake. Redirects from M (mispredicted jXX) and W (ret),
//   taken jXX/call, ret, halt and faults all steer the fetch PC.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   imem_req/imem_addr  instruction memory read request and start address
//   imem_rdata/imem_err read data (byte i at [8i+7:8i]) and fault, one cycle later
//   M_icode/M_Cnd/M_valA  M-stage jXX information for mispredict recovery
//   W_icode/W_valM      W-stage ret information for return recovery
//   f_ready             decode accepts the offered instruction
//   f_valid, f_*        decoded instruction at the queue head
module fetch_prefetch_q #(
  parameter int          FETCH_BYTES = 4,
  parameter int          QDEPTH      = 16,
  parameter logic [63:0] MEM_BYTES   = 64'd4096,
  parameter logic [63:0] RESET_PC    = 64'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [63:0]              imem_addr,
  input  logic [8*FETCH_BYTES-1:0] imem_rdata,
  input  logic                     imem_err,
  input  logic [3:0]               M_icode,
  input  logic                     M_Cnd,
  input  logic [63:0]              M_valA,
  input  logic [3:0]               W_icode,
  input  logic [63:0]              W_valM,
  input  logic                     f_ready,
  output logic                     f_valid,
  output logic [63:0]              f_pc,
  output logic [3:0]               f_stat,
  output logic [3:0]               f_icode,
  output logic [3:0]               f_ifun,
  output logic [3:0]               f_rA,
  output logic [3:0]               f_rB,
  output logic [63:0]              f_valC,
  output logic [63:0]              f_valP,
  output logic [63:0]              f_predPC
);

  localparam int PW = $clog2(QDEPTH);

  typedef enum logic [1:0] {RUN, WAIT_RET, HALTED} state_t;

  state_t        state;
  logic [7:0]    q_data [QDEPTH];
  logic          q_err  [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic [63:0]   fetch_pc, head_pc, resp_addr;
  logic          inflight;

  logic          redirect;
  logic [63:0]   redirect_pc;
  logic [7:0]    hb [10];
  logic          he [10];
  logic          hp [10];
  logic [3:0]    raw_icode, raw_len, dec_icode, dec_ifun, dec_len, dec_ra, dec_rb, dec_stat;
  logic [63:0]   dec_valc, dec_valp, dec_pred;
  logic          adr, head_ok, valid, pop, ctrl_jump, ctrl_ret, ctrl_halt, flush, room, req;
  logic [PW+1:0] occ;

  // W-stage ret has priority over an M-stage mispredict.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (W_icode == 4'h9) begin
      redirect    = 1'b1;
      redirect_pc = W_valM;
    end else if (M_icode == 4'h7 && !M_Cnd) begin
      redirect    = 1'b1;
      redirect_pc = M_valA;
    end
  end

  // Look at the first ten queue bytes (longest instruction), with presence flags.
  always_comb begin
    for (int j = 0; j < 10; j++) begin
      hb[j] = q_data[rd_ptr + PW'(j)];
      he[j] = q_err[rd_ptr + PW'(j)];
      hp[j] = (PW+1)'(j) < count;
    end
  end

  // Head decode. A fault on any present byte of the instruction ends the wait
  // for the rest of it and turns it into a one-byte ADR instruction.
  always_comb begin
    raw_icode = hb[0][7:4];
    case (raw_icode)
      4'h2, 4'h6, 4'hA, 4'hB: raw_len = 4'd2;
      4'h7, 4'h8:             raw_len = 4'd9;
      4'h3, 4'h4, 4'h5:       raw_len = 4'd10;
      default:                raw_len = 4'd1;
    endcase
    adr = 1'b0;
    for (int j = 0; j < 10; j++)
      if (4'(j) < raw_len && hp[j] && he[j]) adr = 1'b1;
    head_ok = adr || (count >= (PW+1)'(raw_len));

    dec_icode = raw_icode;
    dec_ifun  = hb[0][3:0];
    dec_len   = raw_len;
    dec_ra    = 4'hF;
    dec_rb    = 4'hF;
    dec_valc  = '0;
    if (raw_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
      dec_ra = hb[1][7:4];
      dec_rb = hb[1][3:0];
    end
    for (int j = 0; j < 8; j++) begin
      if (raw_icode inside {4'h3, 4'h4, 4'h5})
        dec_valc[63-8*j -: 8] = hb[2+j];
      else if (raw_icode inside {4'h7, 4'h8})
        dec_valc[63-8*j -: 8] = hb[1+j];
    end

    if (adr) begin
      dec_stat  = 4'b0010;
      dec_icode = 4'h1;
      dec_ifun  = 4'h0;
      dec_len   = 4'd1;
      dec_ra    = 4'hF;
      dec_rb    = 4'hF;
      dec_valc  = '0;
    end else if (raw_icode > 4'hB) begin
      dec_stat = 4'b0001;
    end else if (raw_icode == 4'h0) begin
      dec_stat = 4'b0100;
    end else begin
      dec_stat = 4'b1000;
    end

    dec_valp = head_pc + 64'(dec_len);
    dec_pred = (dec_icode == 4'h7 || dec_icode == 4'h8) ? dec_valc : dec_valp;
  end

  // Handshake and control flow. Requests stop in any cycle that will flush or
  // leave RUN, so nothing is ever in flight across a change of stream.
  always_comb begin
    valid     = (state == RUN) && !redirect && head_ok;
    pop       = valid && f_ready;
    ctrl_jump = pop && (dec_icode == 4'h7 || dec_icode == 4'h8);
    ctrl_ret  = pop && (dec_icode == 4'h9) && (dec_stat == 4'b1000);
    ctrl_halt = pop && (dec_stat != 4'b1000);
    flush     = redirect || ctrl_jump;
    occ       = {1'b0, count} + (inflight ? (PW+2)'(FETCH_BYTES) : '0);
    room      = (occ + (PW+2)'(FETCH_BYTES)) <= (PW+2)'(QDEPTH);
    req       = !rst && (state == RUN) && !flush && !ctrl_ret && !ctrl_halt && room;
  end

  assign imem_req  = req;
  assign imem_addr = fetch_pc;

  // Outputs read zero whenever nothing is offered.
  assign f_valid  = valid;
  assign f_pc     = valid ? head_pc   : '0;
  assign f_stat   = valid ? dec_stat  : '0;
  assign f_icode  = valid ? dec_icode : '0;
  assign f_ifun   = valid ? dec_ifun  : '0;
  assign f_rA     = valid ? dec_ra    : '0;
  assign f_rB     = valid ? dec_rb    : '0;
  assign f_valC   = valid ? dec_valc  : '0;
  assign f_valP   = valid ? dec_valp  : '0;
  assign f_predPC = valid ? dec_pred  : '0;

  // Queue storage; a response is dropped on reset or flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush && inflight) begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
        q_data[wr_ptr + PW'(i)] <= imem_rdata[8*i +: 8];
        q_err[wr_ptr + PW'(i)]  <= imem_err || ((resp_addr + 64'(i)) >= MEM_BYTES);
      end
    end
  end

  // Pointers, PCs, in-flight tracking and the RUN/WAIT_RET/HALTED state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fetch_pc  <= RESET_PC;
      head_pc   <= RESET_PC;
      resp_addr <= '0;
      inflight  <= 1'b0;
    end else if (flush) begin
      state    <= RUN;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      fetch_pc <= redirect ? redirect_pc : dec_valc;
      head_pc  <= redirect ? redirect_pc : dec_valc;
    end else begin
      if (inflight) wr_ptr <= wr_ptr + PW'(FETCH_BYTES);
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(dec_len);
        head_pc <= dec_valp;
      end
      count <= count + (inflight ? (PW+1)'(FETCH_BYTES) : '0) - (pop ? (PW+1)'(dec_len) : '0);
      inflight <= req;
      if (req) begin
        resp_addr <= fetch_pc;
        fetch_pc  <= fetch_pc + 64'(FETCH_BYTES);
      end
      if (ctrl_ret)       state <= WAIT_RET;
      else if (ctrl_halt) state <= HALTED;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_q.sv
// tb_fetch_prefetch_q
//   Directed bench for fetch_prefetch_q. A small byte-array instruction memory
//   answers requests one cycle later; a hand-written Y-86 program walks through
//   straight-line code, a decode stall, a jump, a mispredict, call/ret, halt,
//   an address fault at the top of memory, reset and an invalid opcode.
module tb_fetch_prefetch_q;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic        f_ready;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [3:0]  f_stat, f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP, f_predPC;

  logic [7:0]  mem [4096];
  int          check_count = 0;
  int          err_count   = 0;

  fetch_prefetch_q dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .f_ready(f_ready), .f_valid(f_valid), .f_pc(f_pc), .f_stat(f_stat),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .f_predPC(f_predPC)
  );

  always #5 clk = ~clk;

  // One-cycle instruction memory; addresses outside the array read as zero.
  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return (a < 64'd4096) ? mem[a[11:0]] : 8'h00;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      imem_rdata[8*i +: 8] <= mem_byte(imem_addr + 64'(i));
  end

  task automatic put_bytes(input int a, input int n, input logic [79:0] v);
    for (int i = 0; i < n; i++) mem[a+i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] w_icode, input logic [63:0] w_valm,
                               input logic [3:0] m_icode, input logic m_cnd, input logic [63:0] m_vala);
    W_icode = w_icode;
    W_valM  = w_valm;
    M_icode = m_icode;
    M_Cnd   = m_cnd;
    M_valA  = m_vala;
  endtask

  // Called at a negedge; returns at a negedge with f_valid high or after a timeout.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!f_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!f_valid) checkOutput({tag, "_timeout"}, {63'd0, f_valid}, 64'd1);
  endtask

  task automatic check_instr(input string tag, input logic [63:0] pc, input logic [3:0] stat,
                             input logic [3:0] icode, input logic [3:0] ifun,
                             input logic [3:0] ra, input logic [3:0] rb,
                             input logic [63:0] valc, input logic [63:0] valp, input logic [63:0] pred);
    wait_valid(tag);
    checkOutput({tag, "_pc"},    f_pc,     pc);
    checkOutput({tag, "_stat"},  f_stat,   stat);
    checkOutput({tag, "_icode"}, f_icode,  icode);
    checkOutput({tag, "_ifun"},  f_ifun,   ifun);
    checkOutput({tag, "_rA"},    f_rA,     ra);
    checkOutput({tag, "_rB"},    f_rB,     rb);
    checkOutput({tag, "_valC"},  f_valC,   valc);
    checkOutput({tag, "_valP"},  f_valP,   valp);
    checkOutput({tag, "_pred"},  f_predPC, pred);
  endtask

  // Check, then let the instruction be accepted on the next rising edge.
  task automatic expect_instr(input string tag, input logic [63:0] pc, input logic [3:0] stat,
                              input logic [3:0] icode, input logic [3:0] ifun,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] valc, input logic [63:0] valp, input logic [63:0] pred);
    check_instr(tag, pc, stat, icode, ifun, ra, rb, valc, valp, pred);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      checkOutput({tag, "_req"},   {63'd0, imem_req}, 64'd0);
      checkOutput({tag, "_valid"}, {63'd0, f_valid},  64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    put_bytes('h000, 10, 80'h30F3_0000_0000_0000_0001);
    put_bytes('h00A, 2, 80'h2012);
    put_bytes('h00C, 2, 80'h6001);
    put_bytes('h00E, 2, 80'hA02F);
    put_bytes('h010, 1, 80'h10);
    put_bytes('h011, 1, 80'h10);
    put_bytes('h012, 2, 80'hB03F);
    put_bytes('h014, 9, 80'h70_0000_0000_0000_0040);
    put_bytes('h01D, 1, 80'hF0);
    put_bytes('h01E, 9, 80'h80_0000_0000_0000_0060);
    put_bytes('h040, 10, 80'h30F2_0102_0304_0506_0708);
    put_bytes('h060, 1, 80'h90);
    put_bytes('h080, 1, 80'h00);
    put_bytes('hFFF, 1, 80'h30);

    rst      = 1'b1;
    f_ready  = 1'b1;
    imem_err = 1'b0;
    applyStimulus(4'h0, 64'd0, 4'h0, 1'b0, 64'd0);
    repeat (2) @(negedge clk);

    checkOutput("reset_valid", {63'd0, f_valid},  64'd0);
    checkOutput("reset_req",   {63'd0, imem_req}, 64'd0);
    checkOutput("reset_pc",    f_pc,              64'd0);
    checkOutput("reset_stat",  f_stat,            64'd0);
    rst = 1'b0;

    $display("[TB] straight-line code");
    expect_instr("irmovq", 64'h00, 4'b1000, 4'h3, 4'h0, 4'hF, 4'h3, 64'd1, 64'h0A, 64'h0A);

    $display("[TB] decode stall with a full queue");
    f_ready = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", {63'd0, f_valid},  64'd1);
      checkOutput("stall_pc",    f_pc,              64'h0A);
      checkOutput("stall_icode", f_icode,           64'h2);
      checkOutput("stall_rA",    f_rA,              64'h1);
      checkOutput("stall_req",   {63'd0, imem_req}, 64'd0);
      @(negedge clk);
    end
    f_ready = 1'b1;

    expect_instr("rrmovq", 64'h0A, 4'b1000, 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'h0C, 64'h0C);
    expect_instr("opq",    64'h0C, 4'b1000, 4'h6, 4'h0, 4'h0, 4'h1, 64'd0, 64'h0E, 64'h0E);
    expect_instr("pushq",  64'h0E, 4'b1000, 4'hA, 4'h0, 4'h2, 4'hF, 64'd0, 64'h10, 64'h10);
    expect_instr("nop1",   64'h10, 4'b1000, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h11, 64'h11);
    expect_instr("nop2",   64'h11, 4'b1000, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h12, 64'h12);
    expect_instr("popq",   64'h12, 4'b1000, 4'hB, 4'h0, 4'h3, 4'hF, 64'd0, 64'h14, 64'h14);

    $display("[TB] jump, then mispredict while the target is offered");
    expect_instr("jmp",    64'h14, 4'b1000, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h1D, 64'h40);
    f_ready = 1'b0;
    check_instr("jtarget", 64'h40, 4'b1000, 4'h3, 4'h0, 4'hF, 4'h2, 64'h0102030405060708, 64'h4A, 64'h4A);
    applyStimulus(4'h0, 64'd0, 4'h7, 1'b0, 64'h1E);
    f_ready = 1'b1;
    #1;
    checkOutput("mispredict_valid", {63'd0, f_valid}, 64'd0);
    @(negedge clk);
    applyStimulus(4'h0, 64'd0, 4'h0, 1'b0, 64'd0);

    $display("[TB] call and ret");
    expect_instr("call", 64'h1E, 4'b1000, 4'h8, 4'h0, 4'hF, 4'hF, 64'h60, 64'h27, 64'h60);
    expect_instr("ret",  64'h60, 4'b1000, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0,  64'h61, 64'h61);
    check_idle("wait_ret", 3);
    applyStimulus(4'h9, 64'h80, 4'h7, 1'b0, 64'h1E);
    #1;
    checkOutput("ret_redirect_valid", {63'd0, f_valid}, 64'd0);
    @(negedge clk);
    applyStimulus(4'h0, 64'd0, 4'h0, 1'b0, 64'd0);

    $display("[TB] halt, then fault at the top of memory");
    expect_instr("halt", 64'h80, 4'b0100, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h81, 64'h81);
    check_idle("halted", 4);
    applyStimulus(4'h9, 64'hFFF, 4'h0, 1'b0, 64'd0);
    @(negedge clk);
    applyStimulus(4'h0, 64'd0, 4'h0, 1'b0, 64'd0);
    expect_instr("adr", 64'hFFF, 4'b0010, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h1000, 64'h1000);
    check_idle("adr_halted", 4);

    $display("[TB] reset and invalid opcode");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_req",   {63'd0, imem_req}, 64'd0);
    checkOutput("rst_valid", {63'd0, f_valid},  64'd0);
    rst = 1'b0;
    expect_instr("rst_irmovq", 64'h00, 4'b1000, 4'h3, 4'h0, 4'hF, 4'h3, 64'd1, 64'h0A, 64'h0A);
    applyStimulus(4'h9, 64'h1D, 4'h0, 1'b0, 64'd0);
    #1;
    checkOutput("w_redirect_valid", {63'd0, f_valid}, 64'd0);
    @(negedge clk);
    applyStimulus(4'h0, 64'd0, 4'h0, 1'b0, 64'd0);
    expect_instr("ins", 64'h1D, 4'b0001, 4'hF, 4'h0, 4'hF, 4'hF, 64'd0, 64'h1E, 64'h1E);
    check_idle("ins_halted", 2);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
